// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC sequencer slice.
//   - mac_state_t : sequencer FSM state encoding
//   - *_DEF       : default datapath widths and vector length
//   - clamp_len   : helper that limits a requested pair count to the buffer depth
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int DATA_W_DEF  = 8;   // signed weight / input width
    localparam int PSUM_W_DEF  = 16;  // signed bias / partial-sum width
    localparam int ACC_W_DEF   = 32;  // signed accumulator / result width
    localparam int VEC_LEN_DEF = 8;   // operand buffer depth

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        RUN     = 3'd2,
        BIAS    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } mac_state_t;

    // Limit a requested pair count to the number of buffer entries.
    function automatic int unsigned clamp_len(input int unsigned req,
                                              input int unsigned depth);
        return (req > depth) ? depth : req;
    endfunction

endpackage

// File: rtl/mac_sat.sv
// ---------------------------------------------------------------------------
// mac_sat
// Combinational signed saturator: clips an ACC_W-bit two's-complement value
// to the signed PSUM_W range and sign-extends the clipped value back to ACC_W.
// Only instantiated by mac_sequencer when MAC_SEQ_SAT_EN is defined.
//
// Ports:
//   acc     in  ACC_W  value to be saturated
//   sat     out ACC_W  saturated, sign-extended value
//   clipped out 1      high when acc lies outside the PSUM_W range
// ---------------------------------------------------------------------------
module mac_sat
    import mac_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PSUM_W = PSUM_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] sat,
    output logic             clipped
);

    localparam int EXT_W = ACC_W - PSUM_W;

    localparam logic [ACC_W-1:0] SAT_MAX = {{(EXT_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {{(EXT_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

    // The value fits in PSUM_W bits exactly when every bit above the PSUM_W
    // sign bit repeats that sign bit.
    logic [EXT_W-1:0] ext_agree;

    generate
        for (genvar gi = 0; gi < EXT_W; gi++) begin : g_agree
            assign ext_agree[gi] = (acc[PSUM_W+gi] == acc[PSUM_W-1]);
        end
    endgenerate

    assign clipped = ~(&ext_agree);

    // Direction of clipping follows the true (ACC_W) sign.
    assign sat = !clipped        ? acc     :
                 acc[ACC_W-1]    ? SAT_MIN : SAT_MAX;

endmodule

// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// mac_sequencer
// Sequences the shared mac_unit datapath for one dot product plus bias:
// clear accumulator, stream len weight/input pairs out of the operand
// buffers, add the bias, capture the result and pulse done.
//
// Optional feature: define MAC_SEQ_SAT_EN to saturate the captured result to
// the signed PSUM_W range and report clipping on overflow. Without it the
// result is mac_acc unmodified and overflow is tied low.
//
// Ports:
//   clk          in   system clock (CLOCK_50 at top level)
//   rst          in   asynchronous active-high reset
//   start        in   begin a run (sampled only in IDLE)
//   len          in   pair count, latched and clamped to VEC_LEN at start
//   bias         in   signed bias, latched at start
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse after result has been updated
//   result       out  signed result, held until the next capture
//   overflow     out  saturation flag
//   rd_en        out  operand buffer read strobe
//   rd_addr      out  operand buffer address
//   w_rdata      in   weight read data (one cycle after rd_en)
//   x_rdata      in   input read data (one cycle after rd_en)
//   mac_clear    out  zero the accumulator
//   mac_acc_en   out  accumulate mac_w*mac_x
//   mac_bias_en  out  accumulate mac_psum
//   mac_w        out  weight to the MAC (wire from w_rdata)
//   mac_x        out  input to the MAC (wire from x_rdata)
//   mac_psum     out  latched bias to the MAC
//   mac_acc      in   accumulator value
// ---------------------------------------------------------------------------
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int ADDR_W  = $clog2(VEC_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [PSUM_W-1:0] bias,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] w_rdata,
    input  logic [DATA_W-1:0] x_rdata,
    output logic              mac_clear,
    output logic              mac_acc_en,
    output logic              mac_bias_en,
    output logic [DATA_W-1:0] mac_w,
    output logic [DATA_W-1:0] mac_x,
    output logic [PSUM_W-1:0] mac_psum,
    input  logic [ACC_W-1:0]  mac_acc
);

    localparam logic [ADDR_W:0] VEC_LEN_L = (ADDR_W+1)'(clamp_len(VEC_LEN, VEC_LEN));

    mac_state_t        state_reg, state_next;
    logic [ADDR_W:0]   len_reg;
    logic [PSUM_W-1:0] bias_reg;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [ACC_W-1:0]  result_reg;
    logic              overflow_reg;

    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   len_last;
    logic              run_last;

    logic [ACC_W-1:0]  capture_value;
    logic              capture_ovf;

    // Clamp before latching so rd_addr can never leave the buffer.
    assign len_clamped = (len > VEC_LEN_L) ? VEC_LEN_L : len;

    // Only meaningful in RUN, where len_reg is at least 1.
    assign len_last = len_reg - (ADDR_W+1)'(1);
    assign run_last = ({1'b0, cnt_reg} == len_last);

    // -----------------------------------------------------------------------
    // Result path: optional saturation of the accumulator at capture time
    // -----------------------------------------------------------------------
`ifdef MAC_SEQ_SAT_EN
    logic [ACC_W-1:0] sat_value;
    logic             sat_clip;

    mac_sat #(
        .ACC_W  (ACC_W),
        .PSUM_W (PSUM_W)
    ) u_mac_sat (
        .acc     (mac_acc),
        .sat     (sat_value),
        .clipped (sat_clip)
    );

    assign capture_value = sat_value;
    assign capture_ovf   = sat_clip;
`else
    assign capture_value = mac_acc;
    assign capture_ovf   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            bias_reg     <= '0;
            cnt_reg      <= '0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            if (state_reg == IDLE && start) begin
                len_reg  <= len_clamped;
                bias_reg <= bias;
            end

            if (state_reg == CAPTURE) begin
                result_reg   <= capture_value;
                overflow_reg <= capture_ovf;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and per-state strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rd_en       = 1'b0;
        rd_addr     = '0;
        mac_clear   = 1'b0;
        mac_acc_en  = 1'b0;
        mac_bias_en = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                end
            end

            CLEAR: begin
                mac_clear = 1'b1;
                cnt_next  = '0;
                // Prefetch entry 0 so its data is ready in the first RUN cycle.
                if (len_reg != '0) begin
                    rd_en      = 1'b1;
                    rd_addr    = '0;
                    state_next = RUN;
                end else begin
                    state_next = BIAS;
                end
            end

            RUN: begin
                // Accumulate data fetched last cycle while fetching the next
                // entry; the final RUN cycle only consumes.
                mac_acc_en = 1'b1;
                if (run_last) begin
                    state_next = BIAS;
                end else begin
                    rd_en    = 1'b1;
                    rd_addr  = cnt_reg + ADDR_W'(1);
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end

            BIAS: begin
                mac_bias_en = 1'b1;
                state_next  = CAPTURE;
            end

            CAPTURE: begin
                state_next = DONE;
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign result   = result_reg;
    assign overflow = overflow_reg;
    assign mac_w    = w_rdata;
    assign mac_x    = x_rdata;
    assign mac_psum = bias_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_sequencer
// Self-checking bench for mac_sequencer. Provides operand buffers with a
// one-cycle read latency and a simple MAC accumulator, and checks each run
// against a dot-product-plus-bias reference computed directly from the
// buffer contents. Honours MAC_SEQ_SAT_EN for the expected result.
// ---------------------------------------------------------------------------
module tb_mac_sequencer;

    localparam int VEC_LEN = 8;
    localparam int DATA_W  = 8;
    localparam int PSUM_W  = 16;
    localparam int ACC_W   = 32;
    localparam int ADDR_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic [PSUM_W-1:0] bias = '0;
    logic              busy, done, overflow, rd_en;
    logic [ACC_W-1:0]  result;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] w_rdata, x_rdata;
    logic              mac_clear, mac_acc_en, mac_bias_en;
    logic [DATA_W-1:0] mac_w, mac_x;
    logic [PSUM_W-1:0] mac_psum;
    logic [ACC_W-1:0]  mac_acc;

    int tests_run = 0;
    int tests_failed = 0;
    logic [ACC_W-1:0] last_result = '0;

    logic signed [DATA_W-1:0] w_mem [VEC_LEN];
    logic signed [DATA_W-1:0] x_mem [VEC_LEN];

    always #5 clk = ~clk;

    mac_sequencer #(
        .VEC_LEN (VEC_LEN),
        .DATA_W  (DATA_W),
        .PSUM_W  (PSUM_W),
        .ACC_W   (ACC_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .bias        (bias),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .overflow    (overflow),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .w_rdata     (w_rdata),
        .x_rdata     (x_rdata),
        .mac_clear   (mac_clear),
        .mac_acc_en  (mac_acc_en),
        .mac_bias_en (mac_bias_en),
        .mac_w       (mac_w),
        .mac_x       (mac_x),
        .mac_psum    (mac_psum),
        .mac_acc     (mac_acc)
    );

    // Operand buffers: registered read.
    always @(posedge clk) begin
        if (rd_en) begin
            w_rdata <= w_mem[rd_addr];
            x_rdata <= x_mem[rd_addr];
        end
    end

    // MAC datapath stand-in.
    function automatic int sx8(input logic [DATA_W-1:0] v);
        return int'($signed(v));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_acc <= '0;
        end else if (mac_clear) begin
            mac_acc <= '0;
        end else if (mac_acc_en) begin
            mac_acc <= mac_acc + ACC_W'(sx8(mac_w) * sx8(mac_x));
        end else if (mac_bias_en) begin
            mac_acc <= mac_acc + ACC_W'(int'($signed(mac_psum)));
        end
    end

    // Reference: bias + sum of the first min(len, VEC_LEN) products.
    function automatic int ref_dot(input int n, input int b);
        int s;
        s = b;
        for (int i = 0; i < n; i++) begin
            s += int'(w_mem[i]) * int'(x_mem[i]);
        end
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < VEC_LEN; i++) begin
            w_mem[i] = DATA_W'($urandom);
            x_mem[i] = DATA_W'($urandom);
        end
    endtask

    // One complete run. Extra start pulses are issued in cycles pa and pb
    // (cycle numbers counted from the start edge; 0 means none).
    task automatic do_run(input int l, input int b, input int pa, input int pb);
        int lq, n, s, acc_cnt, done_n;
        int addr_q[$];
        logic [ACC_W-1:0] exp_res;
        logic exp_ovf;
        bit seen_done, bad_onehot, bad_busy, bad_hold, bad_addr;
        logic [PSUM_W-1:0] b16;

        lq = (l > VEC_LEN) ? VEC_LEN : l;
        s  = ref_dot(lq, b);
`ifdef MAC_SEQ_SAT_EN
        if (s > 32767) begin
            exp_res = ACC_W'(32767); exp_ovf = 1'b1;
        end else if (s < -32768) begin
            exp_res = ACC_W'(-32768); exp_ovf = 1'b1;
        end else begin
            exp_res = ACC_W'(s); exp_ovf = 1'b0;
        end
`else
        exp_res = ACC_W'(s);
        exp_ovf = 1'b0;
`endif

        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_before_start: busy=%b done=%b, required 0 0", busy, done);
        end
        b16   = PSUM_W'(b);
        len   = (ADDR_W+1)'(l);
        bias  = b16;
        start = 1'b1;

        n = 0; acc_cnt = 0; done_n = 0; seen_done = 0;
        bad_onehot = 0; bad_busy = 0; bad_hold = 0; bad_addr = 0;
        while (!seen_done && n < 40) begin
            @(negedge clk);
            n++;
            start = (n == pa) || (n == pb);
            if (n == 1) begin
                // Inputs change after start: the latched copies must be used.
                len  = (ADDR_W+1)'($urandom);
                bias = PSUM_W'($urandom);
            end
            if (rd_en) begin
                addr_q.push_back(int'(rd_addr));
                if (rd_addr > ADDR_W'(VEC_LEN - 1)) bad_addr = 1;
            end
            if (mac_acc_en) acc_cnt++;
            if (int'(mac_clear) + int'(mac_acc_en) + int'(mac_bias_en) > 1) bad_onehot = 1;
            if (busy !== 1'b1) bad_busy = 1;
            if (done) begin
                seen_done = 1;
                done_n = n;
            end else if (result !== last_result) begin
                bad_hold = 1;
            end
        end

        tests_run++;
        if (!seen_done) begin
            tests_failed++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles, len=%0d", n, l);
        end
        tests_run++;
        if (done_n != lq + 4) begin
            tests_failed++;
            $display("[TB] FAIL done_latency: done at cycle %0d, required %0d", done_n, lq + 4);
        end
        tests_run++;
        if (result !== exp_res) begin
            tests_failed++;
            $display("[TB] FAIL result: got %0d, required %0d", $signed(result), $signed(exp_res));
        end
        tests_run++;
        if (overflow !== exp_ovf) begin
            tests_failed++;
            $display("[TB] FAIL overflow: got %b, required %b", overflow, exp_ovf);
        end
        tests_run++;
        if (addr_q.size() != lq) begin
            tests_failed++;
            $display("[TB] FAIL read_count: got %0d reads, required %0d", addr_q.size(), lq);
        end else begin
            for (int i = 0; i < lq; i++) begin
                if (addr_q[i] != i) bad_addr = 1;
            end
        end
        tests_run++;
        if (bad_addr) begin
            tests_failed++;
            $display("[TB] FAIL read_order: addresses not 0..%0d in order", lq - 1);
        end
        tests_run++;
        if (acc_cnt != lq) begin
            tests_failed++;
            $display("[TB] FAIL acc_cycles: got %0d, required %0d", acc_cnt, lq);
        end
        tests_run++;
        if (bad_onehot || bad_busy) begin
            tests_failed++;
            $display("[TB] FAIL protocol: onehot_err=%b busy_err=%b, required 0 0", bad_onehot, bad_busy);
        end
        tests_run++;
        if (bad_hold) begin
            tests_failed++;
            $display("[TB] FAIL result_hold: result changed before capture, required %0d", $signed(last_result));
        end

        $display("[TB] run len=%0d bias=%0d -> result=%0d overflow=%b done@%0d", l, b,
                 $signed(result), overflow, done_n);
        last_result = exp_res;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({busy, done, overflow, rd_en, rd_addr, mac_clear, mac_acc_en, mac_bias_en,
             mac_psum, result} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: busy=%b done=%b rd_en=%b result=%0h, required all 0",
                     busy, done, rd_en, result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_result = '0;
        $display("[TB] reset released");
    endtask

    task automatic test_nominal();
        logic signed [DATA_W-1:0] wv [VEC_LEN] = '{1, 2, 1, 2, 3, 4, 3, 4};
        logic signed [DATA_W-1:0] xv [VEC_LEN] = '{-1, -2, 1, 2, 4, 3, -4, -3};
        for (int i = 0; i < VEC_LEN; i++) begin
            w_mem[i] = wv[i];
            x_mem[i] = xv[i];
        end
        do_run(8, 10, 0, 0);
    endtask

    task automatic test_empty();
        do_run(0, -5, 0, 0);
    endtask

    task automatic test_clamp_sat();
        for (int i = 0; i < VEC_LEN; i++) begin
            w_mem[i] = 8'sd127;
            x_mem[i] = 8'sd127;
        end
        do_run(15, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        fill_random();
        // Start pulses in a RUN cycle and in the DONE cycle must be ignored;
        // the next run starts in the cycle right after done.
        do_run(8, int'($signed(PSUM_W'($urandom))), 3, 12);
        do_run(int'($urandom_range(0, 8)), int'($signed(PSUM_W'($urandom))), 0, 0);
    endtask

    task automatic test_reset_mid_run();
        bit bad_done;
        fill_random();
        @(negedge clk);
        len   = 4'd8;
        bias  = 16'd100;
        start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        // Cycle 4 is the third RUN cycle.
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, overflow, rd_en, rd_addr, mac_clear, mac_acc_en, mac_bias_en,
             mac_psum, result} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_run: busy=%b rd_en=%b acc_en=%b psum=%0h result=%0h, required all 0",
                     busy, rd_en, mac_acc_en, mac_psum, result);
        end
        bad_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad_done = 1;
            if (i == 4) rst = 1'b0;
        end
        tests_run++;
        if (bad_done) begin
            tests_failed++;
            $display("[TB] FAIL reset_abort: done or busy seen after mid-run reset, required 0");
        end
        last_result = '0;
        $display("[TB] mid-run reset applied and released");
        do_run(5, 7, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 16; r++) begin
            fill_random();
            do_run(int'($urandom_range(0, 15)), int'($signed(PSUM_W'($urandom))), 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_empty();
        test_clamp_sat();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL final_idle: done=%b busy=%b, required 0 0", done, busy);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
